// File: rtl/round_key_expander.sv
// Grasshopper (GOST R 34.12-2015) key schedule: 256-bit master key -> round keys K1..K10.
// Build option KEYGEN_CONST_ROM_EN: iteration constants from a ROM, removing the CONST phase.
module round_key_expander (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [255:0] key_i,
  input  logic [3:0]   rk_sel_i,
  output logic [127:0] rk_o,
  output logic         busy,
  output logic         done_o,
  output logic         key_valid_o
);

  localparam int NUM_KEYS = 10;
  localparam int ITERS    = 32;
  localparam int DATA_W   = 128;

  localparam logic [2047:0] PI_TBL = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Byte k holds the l() coefficient applied to state byte a_k.
  localparam logic [DATA_W-1:0] L_COEF = 128'h9420_8510_C2C0_01FB_01C0_C210_8520_9401;

  typedef enum logic [2:0] {IDLE, CONST, XS, LIN, SWAP} state_t;

`ifdef KEYGEN_CONST_ROM_EN
  localparam state_t FIRST = XS;
`else
  localparam state_t FIRST = CONST;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [DATA_W-1:0] r_fn(input logic [DATA_W-1:0] a);
    logic [7:0] l;
    l = 8'h00;
    for (int k = 0; k < 16; k++) l = l ^ gf_mul(a[8*k +: 8], L_COEF[8*k +: 8]);
    return {l, a[DATA_W-1:8]};
  endfunction

  function automatic logic [DATA_W-1:0] s_fn(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s[8*k +: 8] = PI_TBL[{~a[8*k +: 8], 3'b000} +: 8];
    return s;
  endfunction

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a1, a0, t;
  logic [4:0]          it;        // iteration index i-1, so i = 1..32 fits in 5 bits
  logic [3:0]          rcnt;
  logic [DATA_W-1:0]   keys [NUM_KEYS];
  logic [DATA_W-1:0]   c_cur;
  logic [DATA_W-1:0]   r_src;
  logic [DATA_W-1:0]   r_out;
  logic                last_it;
  logic                store_pair;
  logic [3:0]          kidx_lo, kidx_hi;

`ifdef KEYGEN_CONST_ROM_EN
  function automatic logic [DATA_W-1:0] l_full(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = a;
    for (int k = 0; k < 16; k++) v = r_fn(v);
    return v;
  endfunction

  logic [DATA_W-1:0] c_rom [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_crom
    assign c_rom[g] = l_full(DATA_W'(g + 1));
  end

  assign c_cur = c_rom[it];
  assign r_src = t;
`else
  logic [5:0] i_val;
  assign i_val = {1'b0, it} + 6'd1;
  // The first CONST cycle feeds Vec128(i) straight into the shared R unit.
  assign r_src = (state == CONST && rcnt == 4'd0) ? {{(DATA_W-6){1'b0}}, i_val} : t;
  assign c_cur = t;
`endif

  assign r_out      = r_fn(r_src);
  assign last_it    = (it == 5'(ITERS - 1));
  assign store_pair = (it[2:0] == 3'b111);
  assign kidx_lo    = {1'b0, it[4:3], 1'b0} + 4'd2;
  assign kidx_hi    = kidx_lo + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = FIRST;
      CONST:   if (rcnt == 4'd15) state_nxt = XS;
      XS:      state_nxt = LIN;
      LIN:     if (rcnt == 4'd15) state_nxt = SWAP;
      SWAP:    state_nxt = last_it ? IDLE : FIRST;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a1          <= '0;
      a0          <= '0;
      t           <= '0;
      it          <= '0;
      rcnt        <= '0;
      busy        <= 1'b0;
      done_o      <= 1'b0;
      key_valid_o <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) keys[k] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            keys[0]     <= key_i[255:128];
            keys[1]     <= key_i[127:0];
            a1          <= key_i[255:128];
            a0          <= key_i[127:0];
            it          <= '0;
            rcnt        <= '0;
            busy        <= 1'b1;
            key_valid_o <= 1'b0;
          end
        end
        CONST, LIN: begin
          t    <= r_out;
          rcnt <= rcnt + 4'd1;
        end
        XS: t <= s_fn(a1 ^ c_cur);
        SWAP: begin
          a1 <= t ^ a0;
          a0 <= a1;
          if (store_pair) begin
            keys[kidx_lo] <= t ^ a0;
            keys[kidx_hi] <= a1;
          end
          if (last_it) begin
            busy        <= 1'b0;
            key_valid_o <= 1'b1;
            done_o      <= 1'b1;
          end else begin
            it <= it + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rk_o = '0;
    if (rk_sel_i >= 4'd1 && rk_sel_i <= 4'(NUM_KEYS)) rk_o = keys[rk_sel_i - 4'd1];
  end

endmodule
